// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding, sizing and verdict helper for the SAR search controller.
//   state_t        : FSM states IDLE / TRIAL / VERIFY
//   DEF_WIDTH      : default search width
//   IDX_W          : bit-index width for the default search width
//   verdict_valid  : true when exactly one comparator flag is high
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRIAL,
        VERIFY
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int IDX_W     = $clog2(DEF_WIDTH);

    function automatic logic verdict_valid(input logic lt, input logic eq, input logic gt);
        // An odd number of flags that is not all three means exactly one.
        return (lt ^ eq ^ gt) && !(lt && eq && gt);
    endfunction

endpackage

// File: rtl/sar_search.sv
// sar_search: successive-approximation controller that hunts a target hidden behind a comparator.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start_i   : begin a search (sampled only in IDLE)
//   lt_i      : comparator verdict guess < target
//   eq_i      : comparator verdict guess == target
//   gt_i      : comparator verdict guess > target
//   guess_o   : registered trial value for the comparator
//   busy_o    : search in progress
//   done_o    : one-cycle pulse on the terminating edge
//   found_o   : search ended on an eq verdict (held until next start)
//   error_o   : search aborted on an invalid verdict (held until next start)
//   result_o  : final value (held until next start)
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             lt_i,
    input  logic             eq_i,
    input  logic             gt_i,
    output logic [WIDTH-1:0] guess_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             found_o,
    output logic             error_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int IW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    i_q, i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             error_q, error_d;

    logic             valid;
    logic [WIDTH-1:0] bit_cur, bit_nxt, acc_n;

    assign valid   = verdict_valid(lt_i, eq_i, gt_i);
    assign bit_cur = WIDTH'(1) << i_q;
    // Only used while i_q > 0, so the wrap at i_q == 0 never reaches guess.
    assign bit_nxt = WIDTH'(1) << (i_q - IW'(1));
    // lt means the trial bit is still below the target and is kept.
    assign acc_n   = lt_i ? (acc_q | bit_cur) : (acc_q & ~bit_cur);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        guess_d  = guess_q;
        result_d = result_q;
        i_d      = i_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                guess_d = '0;
                if (start_i) begin
                    acc_d    = '0;
                    i_d      = IW'(WIDTH - 1);
                    guess_d  = WIDTH'(1) << (WIDTH - 1);
                    result_d = '0;
                    found_d  = 1'b0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = TRIAL;
                end
            end
            TRIAL: begin
                if (!valid || eq_i) begin
                    // Terminate: eq exits early with the trial, invalid keeps the partial acc.
                    error_d  = !valid;
                    found_d  = valid;
                    result_d = valid ? guess_q : acc_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    guess_d  = '0;
                    state_d  = IDLE;
                end else if (i_q != '0) begin
                    acc_d   = acc_n;
                    i_d     = i_q - IW'(1);
                    guess_d = acc_n | bit_nxt;
                end else begin
                    acc_d   = acc_n;
                    guess_d = acc_n;
                    state_d = VERIFY;
                end
            end
            VERIFY: begin
                // lt/gt here means the target moved during the search.
                found_d  = valid && eq_i;
                error_d  = !valid;
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                guess_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                guess_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            guess_q  <= '0;
            result_q <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            i_q      <= i_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    assign guess_o  = guess_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign found_o  = found_q;
    assign error_o  = error_q;
    assign result_o = result_q;

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller: the driving side of a magnitude comparator. It finds an unknown value hidden behind a combinational comparator by presenting trial values on `guess` and consuming the comparator's `lt`/`eq`/`gt` verdict, one trial per clock. It sits between a control master, which issues `start` and reads `result`, and any WIDTH-bit comparator whose second operand holds the unknown target.

## Interface
- `WIDTH`, default 8: width of `guess` and `result`. Legal range is 2 to 16.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a search. Sampled only in IDLE.
- `lt`  in  1  from the comparator: `guess` < target.
- `eq`  in  1  from the comparator: `guess` == target.
- `gt`  in  1  from the comparator: `guess` > target.
- `guess`  out  WIDTH  registered trial value driven to the comparator.
- `busy`  out  1  high from the start-accept edge until the terminating edge.
- `done`  out  1  one-cycle pulse when a search terminates.
- `found`  out  1  the search ended on an `eq` verdict; held until the next start.
- `error`  out  1  the search aborted on an invalid verdict; held until the next start.
- `result`  out  WIDTH  final value; held until the next start.

## Operation
- A verdict is valid only when exactly one of `lt`/`eq`/`gt` is high.
- States:
  - IDLE
  - TRIAL: bit index `i` counts down from WIDTH-1 to 0.
  - VERIFY
- IDLE, on `start`:
  - `acc` <= 0, `i` <= WIDTH-1, `guess` <= 1<<(WIDTH-1).
  - Clear `found`/`error`/`result`; `busy` <= 1; go to TRIAL.
- TRIAL, each edge, using `guess` = `acc` | (1<<`i`):
  - Invalid verdict: `error` <= 1, `result` <= `acc`, `done` pulse, go to IDLE.
  - `eq`: `result` <= `guess`, `found` <= 1, `done` pulse, go to IDLE (early exit).
  - `lt`: `acc` keeps bit `i`.
  - `gt`: `acc` drops bit `i`.
  - Not terminated and `i` > 0: `i` <= `i`-1; next `guess` = new `acc` | (1<<(`i`-1)).
  - Not terminated and `i` == 0: `guess` <= new `acc`; go to VERIFY.
- VERIFY, one edge, `guess` = `acc`:
  - `eq`: `found` <= 1.
  - `lt`/`gt`: `found` <= 0; the target moved or is inconsistent.
  - Invalid verdict: `error` <= 1.
  - In every case: `result` <= `acc`, `done` pulse, go to IDLE.
- `start` while `busy` is ignored. `start` held high in IDLE after a `done` starts a new search immediately.
- `guess` returns to 0 in IDLE. The comparator is never handed a stale trial.

## Timing
- Reset values: all outputs 0; state IDLE; `acc` and `i` at 0.
- Reset mid-search aborts at once with no `done` pulse.
- Edge numbering: `start` is accepted at edge 0.
  - Trials are evaluated at edges 1..WIDTH.
  - VERIFY is evaluated at edge WIDTH+1.
  - `done`/`result`/`found` are registered at the terminating edge.
- Latency:
  - Minimum is 1 cycle: target = 1<<(WIDTH-1).
  - Maximum is WIDTH+1 cycles: the last trial returns `gt`.
- The comparator is combinational. `lt`/`eq`/`gt` must settle within the same cycle that `guess` changes; no extra wait state exists.
- `busy` falls on the same edge on which `done` rises. `busy` and `done` are never both high.

## Structure
- Shared package `sar_pkg`:
  - state enum {IDLE, TRIAL, VERIFY}.
  - localparam `IDX_W` = $clog2(WIDTH).
  - Function `verdict_valid(lt, eq, gt)`.
- No sub-module in RTL; one FSM plus the `acc`/`i` datapath.
- Bench: a behavioural `cmp_model` (WIDTH-bit target register driving `lt`/`eq`/`gt`) with fault-injection hooks.

## Test plan
- Early exit: WIDTH=8, target 128, `start` -> `eq` at edge 1; `done` at edge 1, `result`=128, `found`=1, total 1 cycle.
- Mid-range: target 200 -> `guess` sequence 128, 192, 224, 208, 200; `eq` at edge 5; `result`=200, `found`=1.
- Minimum target: target 0 -> eight `gt` trials, then VERIFY with `guess`=0 and `eq`; `done` at edge 9, `result`=0, `found`=1.
- Maximum target: target 255 -> all `lt`, final trial 255 `eq` at edge 8; `result`=255, `found`=1.
- Faults:
  - Force `lt`=`gt`=1 at trial 3 -> `error`=1, `found`=0, `result`=partial `acc`, `done` pulse.
  - Change target from 0 to 5 before VERIFY -> `found`=0, `error`=0.
- Control corners:
  - `start` pulsed while `busy` is ignored; `guess` sequence unchanged.
  - `rst` asserted at edge 4 -> all outputs 0 at once, no `done`.
  - `start` held high -> back-to-back searches with no idle gap beyond one IDLE cycle.
